// File: rtl/chnl_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | chnl_tx_arbiter: shares one RIFFA TX channel among C_NUM_REQ sources.    |
// | Build option CHNL_TX_ARB_RR_EN selects round-robin; default is fixed.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module chnl_tx_arbiter #(
  parameter [8:0] C_PCI_DATA_WIDTH = 9'd32,
  parameter int   C_NUM_REQ        = 4
) (
  input  logic                                    CLK,
  input  logic                                    RST,
  input  logic [C_NUM_REQ-1:0]                    REQ,
  input  logic [32*C_NUM_REQ-1:0]                 REQ_LEN,
  input  logic [C_PCI_DATA_WIDTH*C_NUM_REQ-1:0]   REQ_DATA,
  input  logic [C_NUM_REQ-1:0]                    REQ_DATA_VALID,
  output logic [C_NUM_REQ-1:0]                    REQ_DATA_REN,
  output logic [C_NUM_REQ-1:0]                    GRANT,
  output logic [C_NUM_REQ-1:0]                    REQ_DONE,
  output logic                                    CHNL_TX_CLK,
  output logic                                    CHNL_TX,
  input  logic                                    CHNL_TX_ACK,
  output logic                                    CHNL_TX_LAST,
  output logic [31:0]                             CHNL_TX_LEN,
  output logic [30:0]                             CHNL_TX_OFF,
  output logic [C_PCI_DATA_WIDTH-1:0]             CHNL_TX_DATA,
  output logic                                    CHNL_TX_DATA_VALID,
  input  logic                                    CHNL_TX_DATA_REN
);

  localparam int              c_WORDS = int'(C_PCI_DATA_WIDTH) / 32;
  localparam int              c_IDXW  = (C_NUM_REQ > 1) ? $clog2(C_NUM_REQ) : 1;
  localparam [c_IDXW:0]       c_NREQ  = (c_IDXW+1)'(C_NUM_REQ);
  localparam [c_IDXW-1:0]     c_LAST  = c_IDXW'(C_NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                      r_state;
  logic [c_IDXW-1:0]           r_gidx;
  logic [C_NUM_REQ-1:0]        r_grant;
  logic [C_NUM_REQ-1:0]        r_done;
  logic                        r_tx;
  logic [31:0]                 r_len;
  logic [31:0]                 r_cnt;

  logic [C_NUM_REQ-1:0]        w_rot;
  logic [c_IDXW-1:0]           w_off;
  logic [c_IDXW-1:0]           w_win_idx;
  logic                        w_win_vld;
  logic [C_NUM_REQ-1:0]        w_win_oh;
  logic [31:0]                 w_win_len;
  logic [C_PCI_DATA_WIDTH-1:0] w_sel_data;
  logic                        w_sel_vld;
  logic                        w_in_data;
  logic                        w_beat;
  logic [32:0]                 w_cnt_nxt;
  logic                        w_last;

`ifdef CHNL_TX_ARB_RR_EN
  logic [c_IDXW-1:0]           r_ptr;
  logic [2*C_NUM_REQ-1:0]      w_dbl;
  logic [c_IDXW:0]             w_sum;

  // Rotate the request vector so the search begins at r_ptr.
  always_comb begin
    w_dbl = {REQ, REQ} >> r_ptr;
    w_rot = w_dbl[C_NUM_REQ-1:0];
  end
`else
  always_comb begin
    w_rot = REQ;
  end
`endif

  always_comb begin
    w_off     = '0;
    w_win_vld = 1'b0;
    for (int k = C_NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off     = c_IDXW'(k);
        w_win_vld = 1'b1;
      end
    end
  end

`ifdef CHNL_TX_ARB_RR_EN
  always_comb begin
    w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= c_NREQ) begin
      w_sum = w_sum - c_NREQ;
    end
    w_win_idx = w_sum[c_IDXW-1:0];
  end
`else
  always_comb begin
    w_win_idx = w_off;
  end
`endif

  always_comb begin
    w_win_oh   = '0;
    w_win_len  = '0;
    w_sel_data = '0;
    w_sel_vld  = 1'b0;
    for (int k = 0; k < C_NUM_REQ; k++) begin
      if (w_win_idx == c_IDXW'(k)) begin
        w_win_oh[k] = 1'b1;
        w_win_len   = REQ_LEN[k*32 +: 32];
      end
      if (r_gidx == c_IDXW'(k)) begin
        w_sel_data = REQ_DATA[k*C_PCI_DATA_WIDTH +: C_PCI_DATA_WIDTH];
        w_sel_vld  = REQ_DATA_VALID[k];
      end
    end
  end

  // Count is widened by one bit so a length near 2^32 cannot wrap the compare.
  always_comb begin
    w_in_data = (r_state == S_DATA);
    w_beat    = w_in_data & w_sel_vld & CHNL_TX_DATA_REN;
    w_cnt_nxt = {1'b0, r_cnt} + 33'(c_WORDS);
    w_last    = (w_cnt_nxt >= {1'b0, r_len});
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_gidx  <= '0;
      r_grant <= '0;
      r_done  <= '0;
      r_tx    <= 1'b0;
      r_len   <= '0;
      r_cnt   <= '0;
`ifdef CHNL_TX_ARB_RR_EN
      r_ptr   <= '0;
`endif
    end else begin
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_win_vld) begin
            r_gidx  <= w_win_idx;
            r_grant <= w_win_oh;
            r_len   <= w_win_len;
            r_cnt   <= '0;
            r_tx    <= 1'b1;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (CHNL_TX_ACK) begin
            if (r_len == 32'd0) begin
              r_tx    <= 1'b0;
              r_done  <= r_grant;
              r_state <= S_DONE;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_beat) begin
            r_cnt <= w_cnt_nxt[31:0];
            if (w_last) begin
              r_tx    <= 1'b0;
              r_done  <= r_grant;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_grant <= '0;
`ifdef CHNL_TX_ARB_RR_EN
          r_ptr   <= (r_gidx == c_LAST) ? '0 : r_gidx + 1'b1;
`endif
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Data path is a pure mux so reset silences it in the same cycle.
  assign REQ_DATA_REN       = (w_in_data && CHNL_TX_DATA_REN) ? r_grant : '0;
  assign CHNL_TX_DATA       = w_in_data ? w_sel_data : '0;
  assign CHNL_TX_DATA_VALID = w_in_data & w_sel_vld;
  assign GRANT              = r_grant;
  assign REQ_DONE           = r_done;
  assign CHNL_TX            = r_tx;
  assign CHNL_TX_LEN        = r_len;
  assign CHNL_TX_CLK        = CLK;
  assign CHNL_TX_LAST       = 1'b1;
  assign CHNL_TX_OFF        = '0;

endmodule
`default_nettype wire

// File: tb/tb_chnl_tx_arbiter.sv
`default_nettype none
// Directed bench for chnl_tx_arbiter: a 32-bit/4-requester instance and a
// 64-bit/2-requester instance sharing ACK and REN, observed through one mux.
module tb_chnl_tx_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ack = 1'b0;
  logic ren_in = 1'b1;
  logic sel = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [3:0]   req32 = '0;
  logic [127:0] len32 = '0;
  logic [127:0] data32;
  logic [3:0]   valid32 = '1;
  logic [3:0]   ren32, grant32, done32;
  logic         txclk32, tx32, last32, vo32;
  logic [31:0]  lo32;
  logic [30:0]  off32;
  logic [31:0]  do32;

  logic [1:0]   req64 = '0;
  logic [63:0]  len64 = '0;
  logic [127:0] data64;
  logic [1:0]   valid64 = '1;
  logic [1:0]   ren64, grant64, done64;
  logic         txclk64, tx64, last64, vo64;
  logic [31:0]  lo64;
  logic [30:0]  off64;
  logic [63:0]  do64;

  logic [15:0]  ptr32 [4];
  logic [15:0]  ptr64 [2];

  always #5 clk = ~clk;

  chnl_tx_arbiter #(.C_PCI_DATA_WIDTH(9'd32), .C_NUM_REQ(4)) dut (
    .CLK(clk), .RST(rst), .REQ(req32), .REQ_LEN(len32), .REQ_DATA(data32),
    .REQ_DATA_VALID(valid32), .REQ_DATA_REN(ren32), .GRANT(grant32), .REQ_DONE(done32),
    .CHNL_TX_CLK(txclk32), .CHNL_TX(tx32), .CHNL_TX_ACK(ack), .CHNL_TX_LAST(last32),
    .CHNL_TX_LEN(lo32), .CHNL_TX_OFF(off32), .CHNL_TX_DATA(do32),
    .CHNL_TX_DATA_VALID(vo32), .CHNL_TX_DATA_REN(ren_in));

  chnl_tx_arbiter #(.C_PCI_DATA_WIDTH(9'd64), .C_NUM_REQ(2)) dut64 (
    .CLK(clk), .RST(rst), .REQ(req64), .REQ_LEN(len64), .REQ_DATA(data64[127:0]),
    .REQ_DATA_VALID(valid64), .REQ_DATA_REN(ren64), .GRANT(grant64), .REQ_DONE(done64),
    .CHNL_TX_CLK(txclk64), .CHNL_TX(tx64), .CHNL_TX_ACK(ack), .CHNL_TX_LAST(last64),
    .CHNL_TX_LEN(lo64), .CHNL_TX_OFF(off64), .CHNL_TX_DATA(do64),
    .CHNL_TX_DATA_VALID(vo64), .CHNL_TX_DATA_REN(ren_in));

  // Sources: each word carries a one-hot requester tag and a running index.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) ptr32[i] <= '0;
      else if (valid32[i] && ren32[i]) ptr32[i] <= ptr32[i] + 16'd1;
    end
    for (int i = 0; i < 2; i++) begin
      if (rst) ptr64[i] <= '0;
      else if (valid64[i] && ren64[i]) ptr64[i] <= ptr64[i] + 16'd1;
    end
  end

  always_comb begin
    data32 = '0;
    data64 = '0;
    for (int i = 0; i < 4; i++)
      data32[i*32 +: 32] = {12'hA00, 4'(4'b0001 << i), ptr32[i]};
    for (int i = 0; i < 2; i++)
      data64[i*64 +: 64] = {12'hB00, 4'(4'b0001 << i), 16'(ptr32[0] * 0 + ptr64[i] * 2 + 1),
                            12'hB00, 4'(4'b0001 << i), 16'(ptr64[i] * 2)};
  end

  logic        m_tx, m_valid;
  logic [3:0]  m_grant, m_done, m_ren;
  logic [31:0] m_len;
  logic [63:0] m_data;
  assign m_tx    = sel ? tx64 : tx32;
  assign m_valid = sel ? vo64 : vo32;
  assign m_grant = sel ? {2'b00, grant64} : grant32;
  assign m_done  = sel ? {2'b00, done64} : done32;
  assign m_ren   = sel ? {2'b00, ren64} : ren32;
  assign m_len   = sel ? lo64 : lo32;
  assign m_data  = sel ? do64 : {32'd0, do32};

  // Plays the RIFFA host side for one packet and reports what it saw.
  task automatic drive_tx(input int ackdly, input bit stall, input bit drop,
                          output bit ok, output logic [3:0] g, output logic [31:0] len,
                          output logic [3:0] done, output int beats, output int ren_cyc,
                          output bit order_ok);
    int n;
    logic [31:0] w;
    logic [31:0] exp_w;
    ok = 1'b0; g = '0; len = '0; done = '0; beats = 0; ren_cyc = 0; order_ok = 1'b1;
    exp_w = '0;
    n = 0;
    while (m_tx !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (m_tx !== 1'b1) return;
    g = m_grant;
    len = m_len;
    if (drop) begin
      req32 = '0; req64 = '0;
      len32 = {4{32'd9}}; len64 = {2{32'd9}};
    end
    repeat (ackdly) @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    n = 0;
    while (n < 200) begin
      if (m_done !== 4'b0) begin done = m_done; ok = 1'b1; break; end
      if (stall) begin
        ren_in  = ((n % 6) >= 3);
        valid32 = {4{(n % 2) == 1}};
        valid64 = {2{(n % 2) == 1}};
      end
      #1;
      if (m_ren !== 4'b0) ren_cyc++;
      if (m_valid === 1'b1 && ren_in === 1'b1) begin
        w = m_data[31:0];
        if (w[19:16] !== g) order_ok = 1'b0;
        if (beats > 0 && w !== exp_w) order_ok = 1'b0;
        exp_w = w + (sel ? 32'd2 : 32'd1);
        beats++;
      end
      @(negedge clk);
      n++;
    end
    ren_in = 1'b1; valid32 = '1; valid64 = '1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (grant32 !== 4'b0) begin n_err++; $display("FAIL reset_grant got %b want 0000", grant32); end
    n_cmp++; if (tx32 !== 1'b0) begin n_err++; $display("FAIL reset_tx got %b want 0", tx32); end
    n_cmp++; if (lo32 !== 32'd0) begin n_err++; $display("FAIL reset_len got %0d want 0", lo32); end
    n_cmp++; if (done32 !== 4'b0) begin n_err++; $display("FAIL reset_done got %b want 0000", done32); end
    n_cmp++; if (ren32 !== 4'b0 || vo32 !== 1'b0) begin n_err++; $display("FAIL reset_ren_valid got %b/%b want 0000/0", ren32, vo32); end
    n_cmp++; if (last32 !== 1'b1 || off32 !== 31'd0) begin n_err++; $display("FAIL tie_last_off got %b/%0d want 1/0", last32, off32); end
    n_cmp++; if (txclk32 !== clk) begin n_err++; $display("FAIL tx_clk got %b want %b", txclk32, clk); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    bit ok, ord; logic [3:0] g, d; logic [31:0] l; int b, rc;
    sel = 1'b0; req32 = 4'b0001; len32 = {96'd0, 32'd4};
    drive_tx(2, 1'b0, 1'b1, ok, g, l, d, b, rc, ord);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL basic_timeout got no done want done"); end
    n_cmp++; if (g !== 4'b0001) begin n_err++; $display("FAIL basic_grant got %b want 0001", g); end
    n_cmp++; if (l !== 32'd4) begin n_err++; $display("FAIL basic_len got %0d want 4", l); end
    n_cmp++; if (b != 4 || rc != 4) begin n_err++; $display("FAIL basic_beats got %0d/%0d want 4/4", b, rc); end
    n_cmp++; if (!ord) begin n_err++; $display("FAIL basic_order got bad want in-order"); end
    n_cmp++; if (d !== 4'b0001) begin n_err++; $display("FAIL basic_done got %b want 0001", d); end
    n_cmp++; if (tx32 !== 1'b0) begin n_err++; $display("FAIL basic_tx_low got %b want 0", tx32); end
    @(negedge clk);
    n_cmp++; if (done32 !== 4'b0 || grant32 !== 4'b0) begin n_err++; $display("FAIL basic_after got done %b grant %b want 0000/0000", done32, grant32); end
  endtask

  task automatic test_width64();
    bit ok, ord; logic [3:0] g, d; logic [31:0] l; int b, rc;
    sel = 1'b1; req64 = 2'b01; len64 = {32'd0, 32'd5};
    drive_tx(2, 1'b0, 1'b1, ok, g, l, d, b, rc, ord);
    n_cmp++; if (b != 3 || rc != 3) begin n_err++; $display("FAIL w64_beats got %0d/%0d want 3/3", b, rc); end
    n_cmp++; if (d !== 4'b0001 || !ok || !ord) begin n_err++; $display("FAIL w64_done got %b ok %0d ord %0d want 0001 1 1", d, ok, ord); end
    @(negedge clk);
    sel = 1'b0;
  endtask

  task automatic test_zero_len();
    bit ok, ord; logic [3:0] g, d; logic [31:0] l; int b, rc;
    sel = 1'b0; req32 = 4'b0010; len32 = '0;
    drive_tx(3, 1'b0, 1'b1, ok, g, l, d, b, rc, ord);
    n_cmp++; if (g !== 4'b0010) begin n_err++; $display("FAIL zero_grant got %b want 0010", g); end
    n_cmp++; if (b != 0 || rc != 0) begin n_err++; $display("FAIL zero_beats got %0d/%0d want 0/0", b, rc); end
    n_cmp++; if (d !== 4'b0010 || !ok) begin n_err++; $display("FAIL zero_done got %b want 0010", d); end
    @(negedge clk);
  endtask

  task automatic test_arbitration();
    bit ok, ord; logic [3:0] g, d; logic [31:0] l; int b, rc;
    logic [3:0] exp_g [5];
`ifdef CHNL_TX_ARB_RR_EN
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
    exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    sel = 1'b0; req32 = 4'b1111; len32 = {4{32'd1}};
    for (int k = 0; k < 5; k++) begin
      drive_tx(0, 1'b0, (k == 4), ok, g, l, d, b, rc, ord);
      n_cmp++;
      if (!ok || g !== exp_g[k] || d !== exp_g[k])
        begin n_err++; $display("FAIL arb_order_%0d got grant %b done %b want %b", k, g, d, exp_g[k]); end
    end
    @(negedge clk);
  endtask

  task automatic test_stall();
    bit ok, ord; logic [3:0] g, d; logic [31:0] l; int b, rc;
    sel = 1'b0; req32 = 4'b0100; len32 = {32'd0, 32'd4, 64'd0};
    drive_tx(1, 1'b1, 1'b1, ok, g, l, d, b, rc, ord);
    n_cmp++; if (b != 4) begin n_err++; $display("FAIL stall_beats got %0d want 4", b); end
    n_cmp++; if (!ord) begin n_err++; $display("FAIL stall_order got bad want in-order"); end
    n_cmp++; if (d !== 4'b0100 || !ok) begin n_err++; $display("FAIL stall_done got %b want 0100", d); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok, ord; logic [3:0] g, d; logic [31:0] l; int b, rc, n, beats;
    sel = 1'b0; req32 = 4'b1000; len32 = {32'd8, 96'd0};
    n = 0;
    while (tx32 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    req32 = '0;
    ack = 1'b1; @(negedge clk); ack = 1'b0;
    beats = 0; n = 0;
    while (beats < 2 && n < 50) begin
      #1; if (vo32 === 1'b1 && ren_in === 1'b1) beats++;
      @(negedge clk); n++;
    end
    n_cmp++; if (beats != 2 || ren32 !== 4'b1000) begin n_err++; $display("FAIL mid_setup got beats %0d ren %b want 2 1000", beats, ren32); end
    rst = 1'b1; #1;
    n_cmp++;
    if (tx32 !== 1'b0 || vo32 !== 1'b0 || ren32 !== 4'b0 || grant32 !== 4'b0 || done32 !== 4'b0 || lo32 !== 32'd0)
      begin n_err++; $display("FAIL mid_reset got tx %b v %b ren %b g %b d %b len %0d want all 0", tx32, vo32, ren32, grant32, done32, lo32); end
    @(negedge clk); rst = 1'b0;
    req32 = 4'b1001; len32 = {32'd8, 64'd0, 32'd2};
    @(negedge clk);
    n_cmp++; if (done32 !== 4'b0) begin n_err++; $display("FAIL mid_no_done got %b want 0000", done32); end
    drive_tx(1, 1'b0, 1'b1, ok, g, l, d, b, rc, ord);
    n_cmp++; if (g !== 4'b0001 || d !== 4'b0001 || b != 2 || !ok) begin n_err++; $display("FAIL mid_regrant got g %b d %b beats %0d want 0001 0001 2", g, d, b); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_width64();
    test_zero_len();
    test_arbitration();
    test_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/chnl_tx_arbiter.md
CHNL_TX_ARBITER -- requirements
Module: chnl_tx_arbiter

Interface
REQ-001 SHALL have parameter C_PCI_DATA_WIDTH, default 9'd32, meaning RIFFA data width in bits (32, 64 or 128).
REQ-002 SHALL have parameter C_NUM_REQ, default 4, meaning number of requesters (2..8).
REQ-003 SHALL have port CLK, input, 1, meaning the single clock for all logic.
REQ-004 SHALL have port RST, input, 1, meaning reset; asynchronous, active-high.
REQ-005 SHALL have port REQ, input, C_NUM_REQ, meaning per-requester packet request level.
REQ-006 SHALL have port REQ_LEN, input, 32*C_NUM_REQ, meaning per-requester packet length in 32-bit words.
REQ-007 SHALL have port REQ_DATA, input, C_PCI_DATA_WIDTH*C_NUM_REQ, meaning per-requester data.
REQ-008 SHALL have port REQ_DATA_VALID, input, C_NUM_REQ, meaning per-requester data valid.
REQ-009 SHALL have port REQ_DATA_REN, output, C_NUM_REQ, meaning per-requester data accept.
REQ-010 SHALL have port GRANT, output, C_NUM_REQ, meaning one-hot owner of the TX channel.
REQ-011 SHALL have port REQ_DONE, output, C_NUM_REQ, meaning one-cycle packet-complete pulse.
REQ-012 SHALL have ports CHNL_TX_CLK (out,1), CHNL_TX (out,1), CHNL_TX_ACK (in,1), CHNL_TX_LAST (out,1), CHNL_TX_LEN (out,32), CHNL_TX_OFF (out,31), CHNL_TX_DATA (out,C_PCI_DATA_WIDTH), CHNL_TX_DATA_VALID (out,1), CHNL_TX_DATA_REN (in,1), meaning the RIFFA TX channel.

Function
REQ-013 SHALL drive CHNL_TX_CLK = CLK, CHNL_TX_LAST = 1, CHNL_TX_OFF = 0.
REQ-014 SHALL implement states IDLE, START, DATA, DONE.
REQ-015 IDLE: if any REQ bit is set, SHALL select one winner, latch its REQ_LEN into a 32-bit length register, set GRANT one-hot and go to START on the next edge.
REQ-016 START: SHALL assert CHNL_TX with CHNL_TX_LEN = latched length; on CHNL_TX_ACK SHALL go to DATA, or to DONE if the length is 0.
REQ-017 DATA: SHALL route CHNL_TX_DATA = REQ_DATA[g], CHNL_TX_DATA_VALID = REQ_DATA_VALID[g], REQ_DATA_REN[g] = CHNL_TX_DATA_REN, with all other REQ_DATA_REN bits 0.
REQ-018 A beat SHALL be counted when CHNL_TX_DATA_VALID and CHNL_TX_DATA_REN are both high; the word counter advances by C_PCI_DATA_WIDTH/32 per beat.
REQ-019 On the beat that brings count to >= length, SHALL go to DONE; REQ_DATA_REN SHALL be 0 after that beat (overshoot of a partial last beat allowed).
REQ-020 DONE: SHALL deassert CHNL_TX, pulse REQ_DONE[g] for exactly one cycle, clear GRANT and return to IDLE; minimum gap between packets is one IDLE cycle.
REQ-021 CHNL_TX SHALL stay high from START entry through the final DATA beat.
REQ-022 Changes to REQ or REQ_LEN of the granted requester after the IDLE→START edge SHALL be ignored until DONE.
REQ-023 Outside DATA, CHNL_TX_DATA_VALID and all REQ_DATA_REN bits SHALL be 0.

Reset
REQ-024 On RST, SHALL go to IDLE immediately; GRANT, REQ_DONE, REQ_DATA_REN, CHNL_TX and CHNL_TX_DATA_VALID = 0; CHNL_TX_LEN, counter and length register = 0.
REQ-025 RST mid-packet SHALL abandon the packet with no REQ_DONE pulse; the round-robin pointer SHALL reset to requester 0.

Configuration
REQ-026 With macro CHNL_TX_ARB_RR_EN defined, SHALL arbitrate round-robin: search starts at the requester after the last granted one, pointer updated in DONE.
REQ-027 Without CHNL_TX_ARB_RR_EN, SHALL use fixed priority, lowest index wins; no pointer register.

Verification
REQ-028 W=32, REQ=0b0001, LEN=4, ACK 2 cycles after CHNL_TX, REN always high -> exactly 4 beats, REQ_DONE[0] one pulse, CHNL_TX low next cycle.
REQ-029 W=64, LEN=5 -> 3 beats accepted, count 6, then DONE; no 4th REN.
REQ-030 LEN=0 -> CHNL_TX until ACK, no beats, REQ_DONE pulse.
REQ-031 REQ=0b1111 held, RR_EN defined -> grant order 0,1,2,3,0; undefined -> 0,0,0.
REQ-032 REQ_DATA_VALID toggling, REN stalling 3 cycles -> beats only when both high, data order preserved.
REQ-033 RST asserted mid-DATA after 2 of 8 beats -> all outputs 0 same cycle, no REQ_DONE, next grant from requester 0.
